// File: rtl/ab_pattern_gen.sv
// ab_pattern_gen: programmable a/b stimulus player (optional wrap mode via AB_PATGEN_LOOP_EN)
module ab_pattern_gen #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [HOLD_W+1:0]          wr_data,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic                       a,
    output logic                       b,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = HOLD_W + 2;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    state_t              state_q, state_d;
    logic [DW-1:0]       mem_q [DEPTH];
    logic                a_q, a_d, b_q, b_d;
    logic [AW-1:0]       idx_q, idx_d, ld_idx;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [AW:0]         len_q, len_d, len_in;
    logic [DW-1:0]       ld;
    logic                last;
    assign len_in   = (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
    assign last     = ({1'b0, idx_q} == len_q - 1'b1);
    assign ld_idx   = (state_q == PLAY && !last) ? idx_q + 1'b1 : '0;
    assign ld       = mem_q[ld_idx];
    assign a        = a_q;
    assign b        = b_q;
    assign step_idx = idx_q;
    assign busy     = (state_q == PLAY);
    assign done     = (state_q == DONE);
`ifndef AB_PATGEN_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif
    // pattern memory, writable at any time and deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end
    // next state: start/stop handling, hold countdown and step loading
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        len_d   = len_q;
        case (state_q)
            IDLE: if (start && !stop && len_in != '0) begin
                state_d = PLAY;
                len_d   = len_in;
                idx_d   = '0;
                {hold_d, a_d, b_d} = ld;
            end
            PLAY: if (stop) begin
                state_d = IDLE;
                {a_d, b_d} = 2'b00;
                idx_d   = '0;
                hold_d  = '0;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else if (!last) begin
                idx_d = ld_idx;
                {hold_d, a_d, b_d} = ld;
`ifdef AB_PATGEN_LOOP_EN
            end else if (loop) begin
                idx_d = '0;
                {hold_d, a_d, b_d} = ld;
`endif
            end else begin
                state_d = DONE;
                {a_d, b_d} = 2'b00;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            idx_q   <= '0;
            hold_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_ab_pattern_gen.sv
// tb_ab_pattern_gen: directed vector bench for ab_pattern_gen
module tb_ab_pattern_gen;
    logic       clk, rst, wr_en, start, stop, loop;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic [3:0] cfg_len;
    logic       a, b, busy, done;
    logic [2:0] step_idx;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic       st, sp;
        logic [3:0] len;
        logic       wr;
        logic [2:0] wa;
        logic [5:0] wd;
        logic       ea, eb, ebusy, edone;
        logic [2:0] eidx;
    } vec_t;
    vec_t vt[$];
    ab_pattern_gen #(.DEPTH(8), .HOLD_W(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_len(cfg_len), .start(start), .stop(stop), .loop(loop),
        .a(a), .b(b), .busy(busy), .done(done), .step_idx(step_idx)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic ea, eb, ebusy, edone, input logic [2:0] eidx);
        tests++;
        if ({a, b, busy, done, step_idx} !== {ea, eb, ebusy, edone, eidx}) begin
            fails++;
            $display("FAIL %s: got a=%b b=%b busy=%b done=%b idx=%0d, want a=%b b=%b busy=%b done=%b idx=%0d",
                     nm, a, b, busy, done, step_idx, ea, eb, ebusy, edone, eidx);
        end
    endtask
    task automatic add(input logic st, sp, input logic [3:0] len, input logic wr, input logic [2:0] wa,
                       input logic [5:0] wd, input logic ea, eb, ebusy, edone, input logic [2:0] eidx);
        vt.push_back('{st, sp, len, wr, wa, wd, ea, eb, ebusy, edone, eidx});
    endtask
    task automatic wr(input logic [2:0] ad, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = ad; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_len = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
        tick();
        tick();
        chk("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk("idle1", 0, 0, 0, 0, 0);
        tick();
        chk("idle2", 0, 0, 0, 0, 0);
        // load reference pattern: (a,b,hold) = 000,100,110,010,111
        add(0,0,0, 1,0,6'd0, 0,0,0,0,0);
        add(0,0,0, 1,1,6'd2, 0,0,0,0,0);
        add(0,0,0, 1,2,6'd3, 0,0,0,0,0);
        add(0,0,0, 1,3,6'd1, 0,0,0,0,0);
        add(0,0,0, 1,4,6'd7, 0,0,0,0,0);
        // reference playback; start while busy and start during DONE ignored
        add(1,0,5, 0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0, 1,0,1,0,1);
        add(1,0,1, 0,0,0, 1,1,1,0,2);
        add(0,0,0, 0,0,0, 0,1,1,0,3);
        add(0,0,0, 0,0,0, 1,1,1,0,4);
        add(0,0,0, 0,0,0, 1,1,1,0,4);
        add(0,0,0, 0,0,0, 0,0,0,1,0);
        add(1,0,5, 0,0,0, 0,0,0,0,0);
        // cfg_len=0 ignored, start+stop together ignored
        add(1,0,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0);
        add(1,1,5, 0,0,0, 0,0,0,0,0);
        // abort on the third playback cycle
        add(1,0,5, 0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0, 1,0,1,0,1);
        add(0,0,0, 0,0,0, 1,1,1,0,2);
        add(0,1,0, 0,0,0, 0,0,0,0,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0);
        // live rewrite of entry 3 while step 1 plays
        add(1,0,5, 0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,3,6'd0, 1,1,1,0,2);
        add(0,0,0, 0,0,0, 0,0,1,0,3);
        add(0,0,0, 0,0,0, 1,1,1,0,4);
        add(0,0,0, 0,0,0, 1,1,1,0,4);
        add(0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0);
        // entry 1 = (1,0,hold 2), then rewrite it mid-hold
        add(0,0,0, 1,1,6'd10, 0,0,0,0,0);
        add(1,0,3, 0,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,0, 1,0,1,0,1);
        add(0,0,0, 1,1,6'd1, 1,0,1,0,1);
        add(0,0,0, 0,0,0, 1,0,1,0,1);
        add(0,0,0, 0,0,0, 1,1,1,0,2);
        add(0,0,0, 0,0,0, 0,0,0,1,0);
        add(0,0,0, 0,0,0, 0,0,0,0,0);
        foreach (vt[i]) begin
            start = vt[i].st; stop = vt[i].sp; cfg_len = vt[i].len;
            wr_en = vt[i].wr; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            tick();
            chk($sformatf("vec%0d", i), vt[i].ea, vt[i].eb, vt[i].ebusy, vt[i].edone, vt[i].eidx);
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; cfg_len = '0;
        // cfg_len=9 clamps to 8 steps
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            wr(kk, {4'd0, kk[0], kk[1]});
        end
        start = 1'b1; cfg_len = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            chk($sformatf("len9_step%0d", k), kk[0], kk[1], 1, 0, kk);
            tick();
        end
        chk("len9_done", 0, 0, 0, 1, 0);
        tick();
        chk("len9_idle", 0, 0, 0, 0, 0);
        // maximum hold: 16 cycles
        wr(3'd0, {4'hF, 1'b1, 1'b1});
        start = 1'b1; cfg_len = 4'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("hold15_c%0d", k), 1, 1, 1, 0, 0);
            tick();
        end
        chk("hold15_done", 0, 0, 0, 1, 0);
        tick();
        // reset mid-playback, memory retained
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mem_kept", 1, 1, 1, 0, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        // two-step pattern for loop behaviour
        wr(3'd0, 6'd2);
        wr(3'd1, 6'd1);
        loop = 1'b1; start = 1'b1; cfg_len = 4'd2;
        tick();
        start = 1'b0;
`ifdef AB_PATGEN_LOOP_EN
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("loop%0d_s0", r), 1, 0, 1, 0, 0);
            tick();
            chk($sformatf("loop%0d_s1", r), 0, 1, 1, 0, 1);
            tick();
        end
        loop = 1'b0;
        chk("unloop_s0", 1, 0, 1, 0, 0);
        tick();
        chk("unloop_s1", 0, 1, 1, 0, 1);
        tick();
        chk("unloop_done", 0, 0, 0, 1, 0);
`else
        chk("noloop_s0", 1, 0, 1, 0, 0);
        tick();
        chk("noloop_s1", 0, 1, 1, 0, 1);
        tick();
        chk("noloop_done", 0, 0, 0, 1, 0);
`endif
        loop = 1'b0;
        tick();
        chk("final_idle", 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
